spi_regfile_peripheral: RTL



---
 rtl/spi_regfile_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 52 +++++
 rtl/spi_regfile_peripheral.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    OVER
  } state_e;

  // One rw bit, then the address field, then the data field.
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronisers for sCLK, nCS and COPI, plus edge detection on
// sCLK and nCS. Stage 0 is the first flop; edges compare the last two stages.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic ncs_i,
  input  logic copi_i,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ncs_rise,
  output logic ncs_fall,
  output logic ncs_sync,
  output logic copi_sync
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] ncs_q, ncs_d;
  logic [SYNC_STAGES-1:0] copi_q, copi_d;

  // Shift each pin one stage further down its chain.
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], sclk_i};
    ncs_d  = {ncs_q[SYNC_STAGES-2:0], ncs_i};
    copi_d = {copi_q[SYNC_STAGES-2:0], copi_i};
  end

  // Reset as if the bus were idle: sCLK low, nCS deasserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      ncs_q  <= '1;
      copi_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      ncs_q  <= ncs_d;
      copi_q <= copi_d;
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];
  assign ncs_rise  = ncs_q[SYNC_STAGES-2] & ~ncs_q[SYNC_STAGES-1];
  assign ncs_fall  = ~ncs_q[SYNC_STAGES-2] & ncs_q[SYNC_STAGES-1];
  assign ncs_sync  = ncs_q[SYNC_STAGES-1];
  // COPI is set up half an sCLK period before the rising edge, so the
  // fully delayed copy is stable when the rise is detected.
  assign copi_sync = copi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register file with
// read-back on CIPO, frame-length checking and write/error status pulses.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FB    = frame_bits(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FB + 2);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FB);
  localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FB + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);

  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_sync, copi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk_i    (sCLK),
    .ncs_i     (nCS),
    .copi_i    (COPI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ncs_rise  (ncs_rise),
    .ncs_fall  (ncs_fall),
    .ncs_sync  (ncs_sync),
    .copi_sync (copi_s)
  );

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         rw_q, rw_d;
  logic [ADDR_W-1:0]            addr_q, addr_d, wr_addr_q, wr_addr_d, addr_shift;
  logic [DATA_W-1:0]            data_q, data_d, tx_q, tx_d, data_shift, rd_data;
  logic                         cipo_q, cipo_d, wr_pulse_q, wr_pulse_d;
  logic                         frame_err_q, frame_err_d, wr_hit;
  logic [NUM_REGS*DATA_W-1:0]   regs_d;

  // Frame FSM: shift in rw/address/data, load read data, commit or discard.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_d        = tx_q;
    cipo_d      = cipo_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    wr_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    addr_shift  = (addr_q << 1) | ADDR_W'(copi_s);
    data_shift  = (data_q << 1) | DATA_W'(copi_s);
    // Out-of-range addresses match no register: reads return zero and
    // writes are dropped.
    rd_data = '0;
    wr_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_shift == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
      if (addr_q == ADDR_W'(i))     wr_hit  = 1'b1;
    end

    if (ncs_fall) begin
      state_d = CMD;
      cnt_d   = '0;
      rw_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      tx_d    = '0;
      cipo_d  = 1'b0;
    end else if (ncs_rise) begin
      state_d = IDLE;
      tx_d    = '0;
      cipo_d  = 1'b0;
      if (cnt_q != CNT_FULL) begin
        frame_err_d = 1'b1;
      end else if (rw_q == RW_WRITE && wr_hit) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (addr_q == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = data_q;
        wr_addr_d  = addr_q;
        wr_pulse_d = 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          rw_d = copi_s;
        end else if (cnt_q <= CNT_ADDR_LAST) begin
          addr_d = addr_shift;
          if (cnt_q == CNT_ADDR_LAST && rw_q == RW_READ) tx_d = rd_data;
        end else if (cnt_q < CNT_FULL) begin
          data_d = data_shift;
        end
        if (cnt_d <= CNT_ADDR_LAST)  state_d = ADDR;
        else if (cnt_d <= CNT_FULL)  state_d = DATA;
        else                         state_d = OVER;
      end else if (sclk_fall) begin
        // Present the next bit half a period before the controller samples it.
        cipo_d = tx_q[DATA_W-1];
        tx_d   = tx_q << 1;
      end
    end
  end

  // State and register-file flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
      regs_q      <= '0;
      wr_addr_q   <= '0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
      regs_q      <= regs_d;
      wr_addr_q   <= wr_addr_d;
      wr_pulse_q  <= wr_pulse_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = ~ncs_sync;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
